// File: rtl/exc_monitor.sv
// -----------------------------------------------------------------------------
// exc_monitor
//
// Exception and redirect controller for the fetch stage.
//
// Exception requests on exc_in are latched into a sticky pending register and
// served one at a time, lowest index first. Each cycle the controller picks at
// most one PC redirect. The candidates, highest priority first, are:
//   1. branch-miss recovery
//   2. a stall, which blocks every redirect
//   3. an exception vector
//   4. an ordinary jump
//
// The block also tracks the 2-bit privilege mode. It keeps a saved copy of the
// mode, and eret restores that copy.
//
// Ports:
//   clk, rst       clock; asynchronous active-high reset
//   miss           branch mispredict; redirect to branch_PC
//   jump, new_PC   ordinary jump request and its target
//   branch_PC      mispredict recovery target
//   Mode_Set       mode-change command:
//                    01 -> 00, 10 -> 01, 11 -> {0,Mode[0]}, 00 -> hold
//   eret           return from exception; Mode <= saved mode
//   IFID_Stall     IF/ID stall; suppresses redirects and mode commands
//   exc_in         exception request levels, index 0 = highest priority
//   J, J_R         redirect valid and target (combinational)
//   Store_Current  save the current PC as the return address (combinational)
//   Mode           current privilege mode (registered)
//   Cause          index of the last exception taken (registered)
//   Pending        sticky pending exceptions (registered, for status/debug)
// -----------------------------------------------------------------------------
module exc_monitor #(
    parameter int                 WIDTH      = 16,
    parameter int                 NUM_SRC    = 4,
    parameter logic [WIDTH-1:0]   VEC_BASE   = WIDTH'(16'h0030),
    parameter logic [WIDTH-1:0]   VEC_STRIDE = WIDTH'(16'h0040),
    parameter logic [NUM_SRC-1:0] MASKABLE   = NUM_SRC'(4'b0001),
    localparam int                CW         = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               miss,
    input  logic               jump,
    input  logic [WIDTH-1:0]   new_PC,
    input  logic [WIDTH-1:0]   branch_PC,
    input  logic [1:0]         Mode_Set,
    input  logic               eret,
    input  logic               IFID_Stall,
    input  logic [NUM_SRC-1:0] exc_in,
    output logic               J,
    output logic [WIDTH-1:0]   J_R,
    output logic               Store_Current,
    output logic [1:0]         Mode,
    output logic [CW-1:0]      Cause,
    output logic [NUM_SRC-1:0] Pending
);

    logic [1:0]         saved_mode;
    logic [NUM_SRC-1:0] accept;
    logic [NUM_SRC-1:0] take_mask;
    logic [CW-1:0]      sel;
    logic               take;
    logic [WIDTH-1:0]   vec_addr;

    // While Mode[1] is set, requests on maskable sources are dropped, not queued.
    assign accept = exc_in & ~(MASKABLE & {NUM_SRC{Mode[1]}});

    // Find the lowest set pending index. The loop scans downward, so the
    // lowest set bit is the last one written and wins.
    always_comb begin
        sel = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (Pending[i]) begin
                sel = CW'(i);
            end
        end
    end

    // Vector address arithmetic wraps modulo 2^WIDTH.
    assign vec_addr = VEC_BASE + WIDTH'(sel) * VEC_STRIDE;

    // Redirect selection. Exactly one source wins.
    always_comb begin
        J             = 1'b0;
        J_R           = '0;
        Store_Current = 1'b0;
        take          = 1'b0;
        if (miss) begin
            J   = 1'b1;
            J_R = branch_PC;
        end else if (IFID_Stall) begin
            J   = 1'b0;
        end else if (|Pending) begin
            J             = 1'b1;
            J_R           = vec_addr;
            Store_Current = 1'b1;
            take          = 1'b1;
        end else if (jump) begin
            J   = 1'b1;
            J_R = new_PC;
        end
    end

    assign take_mask = take ? (NUM_SRC'(1) << sel) : '0;

    // A request that arrives in the same cycle its bit is taken must survive.
    // So the clear is applied first and the new accepts are OR-ed in after it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Pending <= '0;
            Cause   <= '0;
        end else begin
            Pending <= (Pending & ~take_mask) | accept;
            if (take) begin
                Cause <= sel;
            end
        end
    end

    // Mode tracking.
    // Accepting an exception raises Mode[1]. The mode is saved only when
    // entering from Mode[1]=0, so a nested exception cannot overwrite the
    // outer save.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Mode       <= 2'b11;
            saved_mode <= 2'b11;
        end else if (|accept) begin
            Mode <= {1'b1, Mode[0]};
            if (!Mode[1]) begin
                saved_mode <= Mode;
            end
        end else if (IFID_Stall) begin
            Mode <= Mode;
        end else if (eret) begin
            Mode <= saved_mode;
        end else begin
            case (Mode_Set)
                2'b01:   Mode <= 2'b00;
                2'b10:   Mode <= 2'b01;
                2'b11:   Mode <= {1'b0, Mode[0]};
                default: Mode <= Mode;
            endcase
        end
    end

endmodule

// File: tb/tb_exc_monitor.sv
// -----------------------------------------------------------------------------
// tb_exc_monitor
//
// Directed bench for exc_monitor with default parameters.
//
// Each table row gives the inputs driven during one clock cycle. It also gives
// the outputs expected in that cycle, before the edge that ends the cycle:
//   - J, J_R and Store_Current are the combinational response to the inputs.
//   - Mode, Cause and Pending are the state left by the previous edge.
//
// After the table, a hand-written sequence checks the asynchronous reset while
// exceptions are still pending.
// -----------------------------------------------------------------------------
module tb_exc_monitor;

    logic        clk;
    logic        rst;
    logic        miss;
    logic        jump;
    logic [15:0] new_PC;
    logic [15:0] branch_PC;
    logic [1:0]  Mode_Set;
    logic        eret;
    logic        IFID_Stall;
    logic [3:0]  exc_in;
    logic        J;
    logic [15:0] J_R;
    logic        Store_Current;
    logic [1:0]  Mode;
    logic [1:0]  Cause;
    logic [3:0]  Pending;

    int n_checks;
    int n_fail;

    exc_monitor dut (
        .clk          (clk),
        .rst          (rst),
        .miss         (miss),
        .jump         (jump),
        .new_PC       (new_PC),
        .branch_PC    (branch_PC),
        .Mode_Set     (Mode_Set),
        .eret         (eret),
        .IFID_Stall   (IFID_Stall),
        .exc_in       (exc_in),
        .J            (J),
        .J_R          (J_R),
        .Store_Current(Store_Current),
        .Mode         (Mode),
        .Cause        (Cause),
        .Pending      (Pending)
    );

    // ---------------------------------------------------------------- clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------------------------------------------------------- vectors
    typedef struct {
        logic        miss;
        logic        jump;
        logic [15:0] new_pc;
        logic [15:0] branch_pc;
        logic [1:0]  mode_set;
        logic        eret;
        logic        stall;
        logic [3:0]  exc;
        logic        j;
        logic [15:0] j_r;
        logic        sc;
        logic [1:0]  mode;
        logic [1:0]  cause;
        logic [3:0]  pend;
    } vec_t;

    function automatic vec_t mk(
        input logic miss_i, input logic jump_i,
        input logic [15:0] npc_i, input logic [15:0] bpc_i,
        input logic [1:0] ms_i, input logic eret_i, input logic stall_i,
        input logic [3:0] exc_i,
        input logic j_i, input logic [15:0] jr_i, input logic sc_i,
        input logic [1:0] mode_i, input logic [1:0] cause_i,
        input logic [3:0] pend_i);
        vec_t v;
        v.miss = miss_i;   v.jump = jump_i;
        v.new_pc = npc_i;  v.branch_pc = bpc_i;
        v.mode_set = ms_i; v.eret = eret_i; v.stall = stall_i;
        v.exc = exc_i;
        v.j = j_i;         v.j_r = jr_i;    v.sc = sc_i;
        v.mode = mode_i;   v.cause = cause_i; v.pend = pend_i;
        return v;
    endfunction

    vec_t tbl[31];

    // ---------------------------------------------------------------- checking
    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        miss       = v.miss;
        jump       = v.jump;
        new_PC     = v.new_pc;
        branch_PC  = v.branch_pc;
        Mode_Set   = v.mode_set;
        eret       = v.eret;
        IFID_Stall = v.stall;
        exc_in     = v.exc;
    endtask

    task automatic drive_idle();
        miss = 1'b0; jump = 1'b0; new_PC = '0; branch_PC = '0;
        Mode_Set = 2'b00; eret = 1'b0; IFID_Stall = 1'b0; exc_in = 4'b0000;
    endtask

    // ---------------------------------------------------------------- stimulus
    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        drive_idle();

        // Row format:
        //   miss jump new_PC branch_PC Mode_Set eret stall exc
        //   | J J_R SC Mode Cause Pending
        // Reset state, then a masked request that must be dropped.
        tbl[0]  = mk(0,0,16'h0,16'h0,2'b00,0,0,4'b0000, 0,16'h0000,0,2'b11,2'd0,4'b0000);
        tbl[1]  = mk(0,0,16'h0,16'h0,2'b00,0,0,4'b0001, 0,16'h0000,0,2'b11,2'd0,4'b0000);
        tbl[2]  = mk(0,0,16'h0,16'h0,2'b00,0,0,4'b0000, 0,16'h0000,0,2'b11,2'd0,4'b0000);
        // Mode_Set 11 -> 01, then 01 -> 00.
        tbl[3]  = mk(0,0,16'h0,16'h0,2'b11,0,0,4'b0000, 0,16'h0000,0,2'b11,2'd0,4'b0000);
        tbl[4]  = mk(0,0,16'h0,16'h0,2'b01,0,0,4'b0000, 0,16'h0000,0,2'b01,2'd0,4'b0000);
        // Single source 2 from user mode.
        tbl[5]  = mk(0,0,16'h0,16'h0,2'b00,0,0,4'b0100, 0,16'h0000,0,2'b00,2'd0,4'b0000);
        tbl[6]  = mk(0,0,16'h0,16'h0,2'b00,0,0,4'b0000, 1,16'h00B0,1,2'b10,2'd0,4'b0100);
        tbl[7]  = mk(0,0,16'h0,16'h0,2'b00,0,0,4'b0000, 0,16'h0000,0,2'b10,2'd2,4'b0000);
        // Two sources in one cycle, served in priority order.
        tbl[8]  = mk(0,0,16'h0,16'h0,2'b00,0,0,4'b1010, 0,16'h0000,0,2'b10,2'd2,4'b0000);
        tbl[9]  = mk(0,0,16'h0,16'h0,2'b00,0,0,4'b0000, 1,16'h0070,1,2'b10,2'd2,4'b1010);
        tbl[10] = mk(0,0,16'h0,16'h0,2'b00,0,0,4'b0000, 1,16'h00F0,1,2'b10,2'd1,4'b1000);
        tbl[11] = mk(0,0,16'h0,16'h0,2'b00,0,0,4'b0000, 0,16'h0000,0,2'b10,2'd3,4'b0000);
        // eret together with Mode_Set: eret wins and restores the saved 00.
        tbl[12] = mk(0,0,16'h0,16'h0,2'b10,1,0,4'b0000, 0,16'h0000,0,2'b10,2'd3,4'b0000);
        tbl[13] = mk(0,0,16'h0,16'h0,2'b00,0,0,4'b0000, 0,16'h0000,0,2'b00,2'd3,4'b0000);
        // Deferral: a miss, then a stall (with a jump present), then the vector.
        tbl[14] = mk(0,0,16'h0,16'h0,2'b00,0,0,4'b0001, 0,16'h0000,0,2'b00,2'd3,4'b0000);
        tbl[15] = mk(1,0,16'h0,16'h1234,2'b00,0,0,4'b0000, 1,16'h1234,0,2'b10,2'd3,4'b0001);
        tbl[16] = mk(0,1,16'h0400,16'h0,2'b00,0,1,4'b0000, 0,16'h0000,0,2'b10,2'd3,4'b0001);
        tbl[17] = mk(0,1,16'h0400,16'h0,2'b00,0,0,4'b0000, 1,16'h0030,1,2'b10,2'd3,4'b0001);
        // Jump path once nothing is pending, then Mode_Set 10 -> 01.
        tbl[18] = mk(0,1,16'h0400,16'h0,2'b00,0,0,4'b0000, 1,16'h0400,0,2'b10,2'd0,4'b0000);
        tbl[19] = mk(0,0,16'h0,16'h0,2'b10,0,0,4'b0000, 0,16'h0000,0,2'b10,2'd0,4'b0000);
        tbl[20] = mk(0,0,16'h0,16'h0,2'b00,0,0,4'b0000, 0,16'h0000,0,2'b01,2'd0,4'b0000);
        // Nesting from mode 01: source 3, then source 2 while in mode 11.
        tbl[21] = mk(0,0,16'h0,16'h0,2'b00,0,0,4'b1000, 0,16'h0000,0,2'b01,2'd0,4'b0000);
        tbl[22] = mk(0,0,16'h0,16'h0,2'b00,0,0,4'b0100, 1,16'h00F0,1,2'b11,2'd0,4'b1000);
        tbl[23] = mk(0,0,16'h0,16'h0,2'b00,0,0,4'b0000, 1,16'h00B0,1,2'b11,2'd3,4'b0100);
        tbl[24] = mk(0,0,16'h0,16'h0,2'b00,1,0,4'b0000, 0,16'h0000,0,2'b11,2'd2,4'b0000);
        tbl[25] = mk(0,0,16'h0,16'h0,2'b00,0,0,4'b0000, 0,16'h0000,0,2'b01,2'd2,4'b0000);
        // A new request on a bit in the cycle it is taken: the accept wins.
        tbl[26] = mk(0,0,16'h0,16'h0,2'b00,0,0,4'b0100, 0,16'h0000,0,2'b01,2'd2,4'b0000);
        tbl[27] = mk(0,0,16'h0,16'h0,2'b00,0,0,4'b0100, 1,16'h00B0,1,2'b11,2'd2,4'b0100);
        tbl[28] = mk(0,0,16'h0,16'h0,2'b00,0,0,4'b0000, 1,16'h00B0,1,2'b11,2'd2,4'b0100);
        // Stall holds Mode even when eret is asserted.
        tbl[29] = mk(0,0,16'h0,16'h0,2'b00,1,1,4'b0000, 0,16'h0000,0,2'b11,2'd2,4'b0000);
        tbl[30] = mk(0,0,16'h0,16'h0,2'b00,0,0,4'b0000, 0,16'h0000,0,2'b11,2'd2,4'b0000);

        // Release reset between edges.
        #12;
        rst = 1'b0;

        for (int i = 0; i < 31; i++) begin
            @(posedge clk);
            #1;
            drive(tbl[i]);
            #1;
            check($sformatf("v%0d.J", i),       {15'd0, J},             {15'd0, tbl[i].j});
            check($sformatf("v%0d.SC", i),      {15'd0, Store_Current}, {15'd0, tbl[i].sc});
            check($sformatf("v%0d.Mode", i),    {14'd0, Mode},          {14'd0, tbl[i].mode});
            check($sformatf("v%0d.Cause", i),   {14'd0, Cause},         {14'd0, tbl[i].cause});
            check($sformatf("v%0d.Pending", i), {12'd0, Pending},       {12'd0, tbl[i].pend});
            // J_R is a don't-care unless a redirect is valid or a stall forces it to 0.
            if (tbl[i].j || tbl[i].stall) begin
                check($sformatf("v%0d.J_R", i), J_R, tbl[i].j_r);
            end
        end

        // Hand sequence: async reset with Pending = 0110.
        // State on entry: Mode=11, Pending=0, Cause=2.
        @(posedge clk); #1; drive_idle(); Mode_Set = 2'b11;   // Mode -> 01
        @(posedge clk); #1; drive_idle(); Mode_Set = 2'b01;   // Mode -> 00
        @(posedge clk); #1; drive_idle(); exc_in = 4'b0110;   // accepted in user mode
        @(posedge clk); #1; drive_idle();
        #1;
        check("pre_rst.Pending", {12'd0, Pending}, 16'h0006);
        check("pre_rst.Mode",    {14'd0, Mode},    16'h0002);
        check("pre_rst.J_R",     J_R,              16'h0070);
        #1;
        rst = 1'b1;
        #1;
        check("rst.Mode",    {14'd0, Mode},    16'h0003);
        check("rst.Pending", {12'd0, Pending}, 16'h0000);
        check("rst.Cause",   {14'd0, Cause},   16'h0000);
        check("rst.J",       {15'd0, J},       16'h0000);
        check("rst.SC",      {15'd0, Store_Current}, 16'h0000);
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #2;
        check("post_rst.J",       {15'd0, J},       16'h0000);
        check("post_rst.Pending", {12'd0, Pending}, 16'h0000);
        check("post_rst.Mode",    {14'd0, Mode},    16'h0003);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/exc_monitor.md
Name: exc_monitor

Overview:
Parametrised exception/redirect controller for the fetch stage. It is the successor to the fixed four-source monitor. It latches NUM_SRC exception requests into a sticky pending register and arbitrates them by fixed priority. It produces a single PC redirect (branch-miss recovery, exception vector, or jump) and tracks the 2-bit privilege mode, including a saved mode restored on exception return.

Parameters:
WIDTH, 16, PC/address width
NUM_SRC, 4, number of exception sources; index 0 = highest priority
VEC_BASE, 16'h0030, vector address of source 0
VEC_STRIDE, 16'h0040, vector spacing; vector(i) = VEC_BASE + i*VEC_STRIDE, truncated to WIDTH
MASKABLE, 4'b0001, NUM_SRC-bit mask; bit i = 1 means source i is ignored while Mode[1] = 1

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
miss  in  1  branch mispredict; highest-priority redirect
jump  in  1  ordinary jump request
new_PC  in  WIDTH  jump target
branch_PC  in  WIDTH  mispredict recovery target
Mode_Set  in  2  mode-change command (01→00, 10→01, 11→{0,Mode[0]}, 00 hold)
eret  in  1  return from exception; restores saved mode
IFID_Stall  in  1  IF/ID stall
exc_in  in  NUM_SRC  exception request levels
J  out  1  redirect valid (comb)
J_R  out  WIDTH  redirect target (comb)
Store_Current  out  1  save current PC as return address (comb)
Mode  out  2  current privilege mode (reg)
Cause  out  log2(NUM_SRC) min 1  index of last taken exception (reg)
Pending  out  NUM_SRC  pending register (reg), for debug/status

Behaviour:
- Reset (async): Mode=2'b11, saved_mode=2'b11, Pending=0, Cause=0. Outputs J=0 and Store_Current=0 while Pending=0 and miss=0 and jump=0.
- Acceptance: accept[i] = exc_in[i] & ~(MASKABLE[i] & Mode[1]), using Mode before the edge.
  - Pending[i] <= 1 on the next edge if accept[i].
  - A bit stays set until taken; accept has priority over clear in the same cycle.
- Latency: a request in cycle N produces a redirect in cycle N+1 at the earliest.
- Redirect priority (combinational, one winner):
  1. miss: J=1, J_R=branch_PC, SC=0.
  2. IFID_Stall: J=0, J_R=0, SC=0.
  3. |Pending: sel = lowest set index; J=1, J_R=vector(sel), SC=1.
  4. jump: J=1, J_R=new_PC, SC=0.
  5. Otherwise: J=0, J_R=don't-care, SC=0.
- Take: on any cycle where priority 3 wins, clear Pending[sel] and set Cause<=sel at the edge. Other pending bits remain and are taken one per unstalled, non-miss cycle in priority order.
- miss or IFID_Stall with Pending≠0: nothing is cleared; the exception is deferred, not lost.
- Mode update priority at each edge:
  1. Any accept: Mode<={1,Mode[0]}. saved_mode<=Mode only if Mode[1]=0, so nesting does not overwrite the user-mode save.
  2. IFID_Stall: hold.
  3. eret: Mode<=saved_mode.
  4. Otherwise: decode Mode_Set.
- eret and Mode_Set in the same cycle: eret wins.
- Requests arriving while Mode[1]=1 on a MASKABLE source are dropped, not queued.
- Reset mid-operation clears Pending immediately; no redirect follows.
- vector(i) arithmetic wraps modulo 2^WIDTH.

Test Plan:
- Reset: assert rst mid-run with Pending=4'b0110 → Mode=11, Pending=0, J=0 asynchronously.
- Single source: Mode=00, exc_in=4'b0100 for 1 cycle → next cycle J=1, J_R=16'h00B0, SC=1, Mode=10, Cause=2. Following cycle Pending=0, J=0.
- Priority/queue: exc_in=4'b1010 in one cycle → J_R=16'h0070 (Cause=1), then 16'h00F0 (Cause=3) on consecutive cycles.
- Deferral: Pending=0001 with miss=1, branch_PC=16'h1234 → J_R=16'h1234, SC=0, Pending kept. Next cycle with IFID_Stall=1 → J=0. Next free cycle → J_R=16'h0030.
- Masking/nesting: Mode=11, exc_in=4'b0001 → Pending stays 0. In Mode=01, take source 3 then source 2 (nested), then eret → Mode=01.
- Jump path: jump=1, new_PC=16'h0400, Pending=0 → J=1, J_R=16'h0400, SC=0. Mode_Set=10 with eret=0 → Mode=01.
